// File: rtl/fpu_pkg.sv
// Shared widths, exponent bias, operand class encoding and result flag
// bundle for the floating-point narrowing path.
package fpu_pkg;

    localparam int unsigned FPU_FW1 = 23;
    localparam int unsigned FPU_FW2 = 40;
    localparam int unsigned FPU_EW1 = 8;
    localparam int unsigned FPU_EW2 = 10;

    // Exponent bias shared by the wide and narrow formats: 2^(ew-1)-1.
    function automatic int unsigned fpu_bias(input int unsigned ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

    localparam int unsigned FPU_BIAS = fpu_bias(FPU_EW1);

    // Operand class after priority resolution (NaN > Inf > Zero > finite).
    // CLS_UF marks a finite operand whose exponent is 0 and is flushed.
    typedef enum logic [2:0] {
        CLS_FIN  = 3'd0,
        CLS_UF   = 3'd1,
        CLS_ZERO = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fclass_t;

    // Result sign, class and exception flags.
    typedef struct packed {
        logic sign;
        logic inf;
        logic nan;
        logic zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

endpackage

// File: rtl/fround.sv
// Round-to-nearest-even increment of a truncated significand.
// A carry out of the increment returns the normalized value 1.000...0;
// the caller bumps the exponent.
module fround #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] i_kept,
    input  logic         i_guard,
    input  logic         i_sticky,
    output logic [W-1:0] o_sig,
    output logic         o_carry,
    output logic         o_inexact
);

    logic         w_inc;
    logic [W:0]   w_sum;

    assign w_inc     = i_guard & (i_sticky | i_kept[0]);
    assign w_sum     = {1'b0, i_kept} + {{W{1'b0}}, w_inc};
    assign o_carry   = w_sum[W];
    assign o_sig     = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : w_sum[W-1:0];
    assign o_inexact = i_guard | i_sticky;

endmodule

// File: rtl/fnarrow.sv
// Wide-to-narrow floating-point conversion with a two-stage valid/ready
// pipeline: S1 classifies and rounds, S2 packs the result and raises flags.
module fnarrow
    import fpu_pkg::*;
#(
    parameter int unsigned FW1 = FPU_FW1,
    parameter int unsigned FW2 = FPU_FW2,
    parameter int unsigned EW1 = FPU_EW1,
    parameter int unsigned EW2 = FPU_EW2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [EW2-1:0] exponentA,
    input  logic [FW2:0]   significantA,
    input  logic           signA,
    input  logic           infA,
    input  logic           nanA,
    input  logic           zeroA,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [EW1-1:0] exponentR,
    output logic [FW1:0]   significantR,
    output logic           signR,
    output logic           infR,
    output logic           nanR,
    output logic           zeroR,
    output logic           overflowR,
    output logic           underflowR,
    output logic           inexactR
);

    localparam logic [EW2:0] L_EMAX    = {{(EW2+1-EW1){1'b0}}, {EW1{1'b1}}};
    localparam logic [FW1:0] L_SIG_ONE = {1'b1, {FW1{1'b0}}};
    localparam logic [FW1:0] L_SIG_QNAN = {2'b11, {(FW1-1){1'b0}}};

    // Truncation split of the wide significand
    logic [FW1:0]   w_kept;
    logic           w_guard;
    logic           w_sticky;
    logic [FW1:0]   w_rnd_sig;
    logic           w_rnd_carry;
    logic           w_rnd_inexact;
    logic [EW2:0]   w_rnd_exp;
    fclass_t        w_class;

    logic           w_s1_ld;
    logic           w_s2_ld;

    logic           r_s1_valid;
    fclass_t        r_s1_class;
    logic           r_s1_sign;
    logic [FW1:0]   r_s1_sig;
    logic [EW2:0]   r_s1_exp;
    logic           r_s1_inexact;

    logic [EW1-1:0] w_s2_exp;
    logic [FW1:0]   w_s2_sig;
    fflags_t        w_s2_flags;

    logic           r_s2_valid;
    logic [EW1-1:0] r_s2_exp;
    logic [FW1:0]   r_s2_sig;
    fflags_t        r_s2_flags;

    assign w_kept   = significantA[FW2:FW2-FW1];
    assign w_guard  = significantA[FW2-FW1-1];
    assign w_sticky = |significantA[FW2-FW1-2:0];

    fround #(.W(FW1 + 1)) u_fround (
        .i_kept    (w_kept),
        .i_guard   (w_guard),
        .i_sticky  (w_sticky),
        .o_sig     (w_rnd_sig),
        .o_carry   (w_rnd_carry),
        .o_inexact (w_rnd_inexact)
    );

    // Exponent carries one extra bit so a round-up past the wide range is still seen
    assign w_rnd_exp = {1'b0, exponentA} + {{EW2{1'b0}}, w_rnd_carry};

    // Stage handshakes: S2 loads when empty or draining, S1 when empty or moving on
    assign w_s2_ld = ~r_s2_valid | ready_i;
    assign w_s1_ld = ~r_s1_valid | w_s2_ld;
    assign ready_o = w_s1_ld;

    // Operand class resolution in priority order
    always_comb begin
        w_class = CLS_FIN;
        if (nanA)
            w_class = CLS_NAN;
        else if (infA)
            w_class = CLS_INF;
        else if (zeroA)
            w_class = CLS_ZERO;
        else if (exponentA == '0)
            w_class = CLS_UF;
    end

    // S1: capture class, sign and rounded significand/exponent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_class   <= CLS_FIN;
            r_s1_sign    <= 1'b0;
            r_s1_sig     <= '0;
            r_s1_exp     <= '0;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_ld) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1_class   <= w_class;
                r_s1_sign    <= signA;
                r_s1_sig     <= w_rnd_sig;
                r_s1_exp     <= w_rnd_exp;
                r_s1_inexact <= w_rnd_inexact;
            end
        end
    end

    // Pack the narrow result; specials bypass rounding and raise no exceptions
    always_comb begin
        w_s2_exp        = '0;
        w_s2_sig        = '0;
        w_s2_flags      = '0;
        w_s2_flags.sign = r_s1_sign;
        case (r_s1_class)
            CLS_NAN: begin
                w_s2_exp        = '1;
                w_s2_sig        = L_SIG_QNAN;
                w_s2_flags.nan  = 1'b1;
                w_s2_flags.sign = 1'b0;
            end
            CLS_INF: begin
                w_s2_exp       = '1;
                w_s2_sig       = L_SIG_ONE;
                w_s2_flags.inf = 1'b1;
            end
            CLS_ZERO: begin
                w_s2_flags.zero = 1'b1;
            end
            CLS_UF: begin
                w_s2_flags.zero      = 1'b1;
                w_s2_flags.underflow = 1'b1;
                w_s2_flags.inexact   = 1'b1;
            end
            default: begin
                if (r_s1_exp >= L_EMAX) begin
                    w_s2_exp            = '1;
                    w_s2_sig            = L_SIG_ONE;
                    w_s2_flags.inf      = 1'b1;
                    w_s2_flags.overflow = 1'b1;
                    w_s2_flags.inexact  = 1'b1;
                end else begin
                    w_s2_exp           = r_s1_exp[EW1-1:0];
                    w_s2_sig           = r_s1_sig;
                    w_s2_flags.inexact = r_s1_inexact;
                end
            end
        endcase
    end

    // S2: registered outputs, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_sig   <= '0;
            r_s2_flags <= '0;
        end else if (w_s2_ld) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_exp   <= w_s2_exp;
                r_s2_sig   <= w_s2_sig;
                r_s2_flags <= w_s2_flags;
            end
        end
    end

    assign valid_o      = r_s2_valid;
    assign exponentR    = r_s2_exp;
    assign significantR = r_s2_sig;
    assign signR        = r_s2_flags.sign;
    assign infR         = r_s2_flags.inf;
    assign nanR         = r_s2_flags.nan;
    assign zeroR        = r_s2_flags.zero;
    assign overflowR    = r_s2_flags.overflow;
    assign underflowR   = r_s2_flags.underflow;
    assign inexactR     = r_s2_flags.inexact;

endmodule

// File: tb/tb_fnarrow.sv
// Directed bench for fnarrow at default widths (23/40 fraction, 8/10 exponent).
module tb_fnarrow;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [9:0]  exponentA;
    logic [40:0] significantA;
    logic        signA, infA, nanA, zeroA;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  exponentR;
    logic [23:0] significantR;
    logic        signR, infR, nanR, zeroR;
    logic        overflowR, underflowR, inexactR;
    logic [6:0]  flags;

    int checks;
    int errors;

    localparam logic [40:0] H    = 41'h100_0000_0000;
    localparam logic [40:0] ONES = 41'h1FF_FFFF_FFFF;

    fnarrow #(.FW1(23), .FW2(40), .EW1(8), .EW2(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .exponentA    (exponentA),
        .significantA (significantA),
        .signA        (signA),
        .infA         (infA),
        .nanA         (nanA),
        .zeroA        (zeroA),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .exponentR    (exponentR),
        .significantR (significantR),
        .signR        (signR),
        .infR         (infR),
        .nanR         (nanR),
        .zeroR        (zeroR),
        .overflowR    (overflowR),
        .underflowR   (underflowR),
        .inexactR     (inexactR)
    );

    // {sign, inf, nan, zero, overflow, underflow, inexact}
    assign flags = {signR, infR, nanR, zeroR, overflowR, underflowR, inexactR};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [9:0] e, input logic [40:0] s,
                         input logic sg, input logic inf, input logic nan, input logic zr);
        exponentA    = e;
        significantA = s;
        signA        = sg;
        infA         = inf;
        nanA         = nan;
        zeroA        = zr;
        valid_i      = 1'b1;
    endtask

    // Present one operand for a single cycle; returns one cycle after acceptance
    task automatic send(input logic [9:0] e, input logic [40:0] s,
                        input logic sg, input logic inf, input logic nan, input logic zr);
        @(negedge clk);
        drive(e, s, sg, inf, nan, zr);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++; if ({exponentR, significantR, flags} !== 39'd0) begin errors++;
            $display("FAIL reset_data: got exp=%h sig=%h flags=%b want all 0", exponentR, significantR, flags); end
        rst_n = 1'b1;
    endtask

    task automatic test_exact();
        send(10'd127, H, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL exact_latency: valid_o got %b want 0 after 1 cycle", valid_o); end
        @(negedge clk);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL exact_valid: got %b want 1", valid_o); end
        checks++; if (exponentR !== 8'h7F || significantR !== 24'h800000 || flags !== 7'b0) begin errors++;
            $display("FAIL exact_one: got exp=%h sig=%h flags=%b want 7f 800000 0000000", exponentR, significantR, flags); end
        // exact value with LSB set, negative sign
        send(10'd130, H + 41'h20000, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'h82 || significantR !== 24'h800001 || flags !== 7'b1000000) begin errors++;
            $display("FAIL exact_lsb: got exp=%h sig=%h flags=%b want 82 800001 1000000", exponentR, significantR, flags); end
    endtask

    task automatic test_rounding();
        // tie, kept LSB 0: stays
        send(10'd127, H + 41'h10000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'h7F || significantR !== 24'h800000 || flags !== 7'b0000001) begin errors++;
            $display("FAIL tie_even: got exp=%h sig=%h flags=%b want 7f 800000 0000001", exponentR, significantR, flags); end
        // tie, kept LSB 1: rounds up to even
        send(10'd127, H + 41'h30000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'h7F || significantR !== 24'h800002 || flags !== 7'b0000001) begin errors++;
            $display("FAIL tie_odd: got exp=%h sig=%h flags=%b want 7f 800002 0000001", exponentR, significantR, flags); end
        // above half (guard + sticky)
        send(10'd127, H + 41'h10001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (significantR !== 24'h800001 || inexactR !== 1'b1) begin errors++;
            $display("FAIL above_half: got sig=%h inexact=%b want 800001 1", significantR, inexactR); end
        // below half (sticky only): truncates, inexact
        send(10'd127, H + 41'h0FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (significantR !== 24'h800000 || inexactR !== 1'b1) begin errors++;
            $display("FAIL below_half: got sig=%h inexact=%b want 800000 1", significantR, inexactR); end
        // carry out without overflow: exponent bumps
        send(10'd100, ONES, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'h65 || significantR !== 24'h800000 || flags !== 7'b0000001) begin errors++;
            $display("FAIL carry: got exp=%h sig=%h flags=%b want 65 800000 0000001", exponentR, significantR, flags); end
    endtask

    task automatic test_overflow();
        send(10'd254, ONES, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'hFF || significantR !== 24'h800000 || flags !== 7'b0100101) begin errors++;
            $display("FAIL ovf_carry: got exp=%h sig=%h flags=%b want ff 800000 0100101", exponentR, significantR, flags); end
        // largest finite exponent without carry
        send(10'd254, H, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'hFE || significantR !== 24'h800000 || flags !== 7'b1000000) begin errors++;
            $display("FAIL max_finite: got exp=%h sig=%h flags=%b want fe 800000 1000000", exponentR, significantR, flags); end
        // exponent beyond narrow range
        send(10'd300, H, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'hFF || significantR !== 24'h800000 || flags !== 7'b1100101) begin errors++;
            $display("FAIL ovf_range: got exp=%h sig=%h flags=%b want ff 800000 1100101", exponentR, significantR, flags); end
    endtask

    task automatic test_specials();
        send(10'd0, H, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'h00 || significantR !== 24'h0 || flags !== 7'b1001011) begin errors++;
            $display("FAIL underflow: got exp=%h sig=%h flags=%b want 00 000000 1001011", exponentR, significantR, flags); end
        send(10'd5, ONES, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (exponentR !== 8'hFF || significantR !== 24'hC00000 || flags !== 7'b0010000) begin errors++;
            $display("FAIL nan: got exp=%h sig=%h flags=%b want ff c00000 0010000", exponentR, significantR, flags); end
        send(10'd0, ONES, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (exponentR !== 8'hFF || significantR !== 24'h800000 || flags !== 7'b1100000) begin errors++;
            $display("FAIL inf: got exp=%h sig=%h flags=%b want ff 800000 1100000", exponentR, significantR, flags); end
        send(10'd0, ONES, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (exponentR !== 8'h00 || significantR !== 24'h0 || flags !== 7'b1001000) begin errors++;
            $display("FAIL zero: got exp=%h sig=%h flags=%b want 00 000000 1001000", exponentR, significantR, flags); end
    endtask

    task automatic test_back_to_back();
        int seenA;
        int seenB;
        seenA = 0;
        seenB = 0;
        @(negedge clk);
        ready_i = 1'b0;
        drive(10'd127, H, 1'b0, 1'b0, 1'b0, 1'b0);            // A
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_s2empty: got %b want 1", ready_o); end
        drive(10'd130, H + 41'h20000, 1'b1, 1'b0, 1'b0, 1'b0); // B
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (valid_o !== 1'b1 || exponentR !== 8'h7F || significantR !== 24'h800000 || flags !== 7'b0) begin errors++;
                $display("FAIL b2b_hold_A[%0d]: got v=%b exp=%h sig=%h flags=%b want 1 7f 800000 0000000", c, valid_o, exponentR, significantR, flags); end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready[%0d]: got %b want 0", c, ready_o); end
            if (c < 2) @(negedge clk);
        end
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1 && exponentR === 8'h7F) seenA++;
            if (valid_o === 1'b1 && exponentR === 8'h82 && significantR === 24'h800001 && signR === 1'b1) seenB++;
            if (c == 0) begin
                checks++; if (valid_o !== 1'b1 || exponentR !== 8'h82 || significantR !== 24'h800001) begin errors++;
                    $display("FAIL b2b_B_next: got v=%b exp=%h sig=%h want 1 82 800001", valid_o, exponentR, significantR); end
            end
        end
        checks++; if (seenA != 0 || seenB != 1) begin errors++;
            $display("FAIL b2b_count: got extraA=%0d B=%0d want 0 1", seenA, seenB); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        ready_i = 1'b0;
        drive(10'd127, H, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(10'd128, H, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0) begin errors++;
            $display("FAIL rst_full: got valid=%b ready=%b want 1 0", valid_o, ready_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++;
            $display("FAIL rst_mid: got valid=%b ready=%b want 0 1", valid_o, ready_o); end
        checks++; if ({exponentR, significantR, flags} !== 39'd0) begin errors++;
            $display("FAIL rst_mid_data: got exp=%h sig=%h flags=%b want 0", exponentR, significantR, flags); end
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d]: valid_o got %b want 0", c, valid_o); end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        valid_i      = 1'b0;
        ready_i      = 1'b1;
        exponentA    = '0;
        significantA = '0;
        signA        = 1'b0;
        infA         = 1'b0;
        nanA         = 1'b0;
        zeroA        = 1'b0;
        test_reset();
        test_exact();
        test_rounding();
        test_overflow();
        test_specials();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
